regfile_dump_reader: RTL and testbench
======================================

// Module: regfile_dump_reader
// PURPOSE
//  Debug/verification reader for the 32x32 MIPS register file. On a start pulse it walks
//  the register file's read port from register 0 to NUM_REGS-1. Each register value leaves
//  on a valid/ready stream tagged with its index, at up to one word per cycle.
//  Sits beside decode and owns a spare read port (readRegister/readData, combinational).
//  Raises freeze so the core can hold regWrite for a consistent snapshot.
// PARAMETERS
//  NUM_REGS    32  registers dumped, indices 0..NUM_REGS-1
//  ADDR_WIDTH   5  register index width; 2**ADDR_WIDTH >= NUM_REGS
//  DATA_WIDTH  32  register width
// PORTS
//  clk           in   1           rising-edge clock
//  rst           in   1           synchronous, active-high reset
//  start         in   1           begin a dump; sampled only in IDLE
//  readRegister  out  ADDR_WIDTH  index driven to the register file read port
//  readData      in   DATA_WIDTH  combinational register file read data for readRegister
//  dumpData      out  DATA_WIDTH  register value being offered
//  dumpIndex     out  ADDR_WIDTH  index of dumpData
//  dumpValid     out  1           dumpData/dumpIndex valid
//  dumpReady     in   1           consumer accepts when dumpValid&&dumpReady at clk edge
//  busy          out  1           high in LOAD or SEND
//  freeze        out  1           equals busy; core must suppress regWrite while high
//  done          out  1           one-cycle pulse after the last word is accepted
// BEHAVIOUR
//  Reset: state=IDLE, rd_ptr=0, dumpData=0, dumpIndex=0, dumpValid=0, done=0.
//   Reset wins over every other event, including mid-dump; the dump aborts and done is not pulsed.
//  readRegister = rd_ptr. dumpData, dumpIndex, dumpValid and done are registered; busy/freeze decode the state.
//  FSM:
//   IDLE: rd_ptr<=0; start -> LOAD.
//   LOAD (one cycle): dumpData<=readData, dumpIndex<=rd_ptr, dumpValid<=1, rd_ptr<=rd_ptr+1 -> SEND.
//   SEND: if !dumpReady, hold all outputs stable (no drop, no change).
//     If accepted and dumpIndex==NUM_REGS-1: dumpValid<=0, done<=1 -> IDLE.
//     If accepted otherwise: reload as in LOAD (dumpData<=readData, dumpIndex<=rd_ptr,
//     rd_ptr<=rd_ptr+1) and stay in SEND. Back-to-back words, one per cycle.
//  Latency: start sampled at edge T -> LOAD during T..T+1 -> dumpValid high after edge T+1.
//   With dumpReady held high, the dump takes NUM_REGS+1 cycles from start to done.
//  start while busy: ignored, no restart. start in the same cycle done is high: accepted (state is IDLE).
//  rd_ptr increments modulo 2**ADDR_WIDTH. The wrapped value after the last word is never
//   used to form an output.
//  done is high for exactly one cycle, and dumpValid is already low in that cycle.
//  Register 0 is dumped like any other index; the expected value is 0.
//  Values reflect register contents at each word's load edge. Snapshot consistency relies on
//   the core honouring freeze.
// STRUCTURE
//  Shared package (mips_pkg): REG_ADDR_W=5, REG_DATA_W=32, NUM_GPR=32, and the state
//   encoding constants IDLE/LOAD/SEND.
//  Single module, no sub-modules. One registered FSM plus the rd_ptr counter and output registers.
// TESTING
//  Preload regs r[i]=32'h1000_0000+i, dumpReady=1, pulse start -> 32 consecutive words,
//   dumpIndex 0..31, r0 reads 0; done pulses 33 cycles after start.
//  Toggle dumpReady every other cycle -> outputs stable while stalled; each of the 32 words
//   delivered exactly once and in order.
//  Hold dumpReady=0 for 10 cycles at index 5 -> dumpIndex=5 and data unchanged, busy=1 throughout.
//  Pulse start at index 12 mid-dump -> ignored; the dump finishes normally with one done pulse.
//  Assert rst at index 20 -> next cycle dumpValid=0, busy=0, done=0; a later start dumps from index 0.
//  Drive start high continuously -> a new dump begins the cycle after done; freeze low for
//   exactly one cycle between dumps.

Source files
------------

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared constants for the MIPS datapath and its debug helpers.
//   REG_ADDR_W  register index width
//   REG_DATA_W  register width
//   NUM_GPR     number of general purpose registers
//   dump_state_e  state encoding of the register-file dump reader
// ---------------------------------------------------------------------------
package mips_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam int NUM_GPR    = 32;

   // IDLE waits for start, LOAD captures register 0, SEND offers words
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// ---------------------------------------------------------------------------
// regfile_dump_reader
// Walks a spare combinational read port of the register file from index 0
// to NUM_REGS-1 and streams every value out on a valid/ready interface,
// tagged with its index, at up to one word per cycle. While a dump is in
// progress freeze is raised so the core can hold off register writes and
// the dump is a consistent snapshot.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   start         begin a dump (only looked at while idle)
//   readRegister  index driven to the register file read port
//   readData      register file read data for readRegister
//   dumpData      register value being offered
//   dumpIndex     index of dumpData
//   dumpValid     dumpData/dumpIndex are valid
//   dumpReady     consumer accepts on dumpValid && dumpReady at clk edge
//   busy          high while a dump is loading or sending
//   freeze        same as busy; core suppresses regWrite while high
//   done          one-cycle pulse after the last word is accepted
// ---------------------------------------------------------------------------
module regfile_dump_reader
   import mips_pkg::*;
#(
   parameter int NUM_REGS   = NUM_GPR,
   parameter int ADDR_WIDTH = REG_ADDR_W,
   parameter int DATA_WIDTH = REG_DATA_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] readRegister,
   input  logic [DATA_WIDTH-1:0] readData,
   output logic [DATA_WIDTH-1:0] dumpData,
   output logic [ADDR_WIDTH-1:0] dumpIndex,
   output logic                  dumpValid,
   input  logic                  dumpReady,
   output logic                  busy,
   output logic                  freeze,
   output logic                  done
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

   dump_state_e           r_state;
   dump_state_e           w_nextState;
   logic [ADDR_WIDTH-1:0] r_rdPtr;
   logic [DATA_WIDTH-1:0] r_dumpData;
   logic [ADDR_WIDTH-1:0] r_dumpIndex;
   logic                  r_dumpValid;
   logic                  r_done;
   logic                  w_accept;
   logic                  w_lastWord;
   logic                  w_load;
   logic                  w_finish;

   assign w_accept   = r_dumpValid && dumpReady;
   assign w_lastWord = (r_dumpIndex == LAST_IDX);

   // State register; reset abandons any dump in flight without a done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state plus the two datapath strobes: w_load captures the word
   // addressed by r_rdPtr, w_finish retires the dump after the last word
   always_comb begin
      w_nextState = r_state;
      w_load      = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_nextState = LOAD;
            end
         end
         LOAD: begin
            w_load      = 1'b1;
            w_nextState = SEND;
         end
         SEND: begin
            if (w_accept) begin
               if (w_lastWord) begin
                  w_finish    = 1'b1;
                  w_nextState = IDLE;
               end else begin
                  w_load = 1'b1;
               end
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Output and pointer registers. A stalled word simply keeps its value
   // because nothing here is written unless w_load or w_finish fires.
   // r_rdPtr wraps after the last load; that wrapped value is never used.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdPtr     <= '0;
         r_dumpData  <= '0;
         r_dumpIndex <= '0;
         r_dumpValid <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (r_state == IDLE) begin
            r_rdPtr <= '0;
         end
         if (w_load) begin
            r_dumpData  <= readData;
            r_dumpIndex <= r_rdPtr;
            r_dumpValid <= 1'b1;
            r_rdPtr     <= r_rdPtr + ADDR_WIDTH'(1);
         end
         if (w_finish) begin
            r_dumpValid <= 1'b0;
         end
      end
   end

   assign readRegister = r_rdPtr;
   assign dumpData     = r_dumpData;
   assign dumpIndex    = r_dumpIndex;
   assign dumpValid    = r_dumpValid;
   assign done         = r_done;
   assign busy         = (r_state != IDLE);
   assign freeze       = busy;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// ---------------------------------------------------------------------------
// tb_regfile_dump_reader
// Drives the dump reader against a behavioural register file. A reference
// model tracks, per dump, the list of words still owed to the consumer and
// whether a word should be on offer; a negedge monitor compares the DUT
// against that list and the expected busy/done flags.
// ---------------------------------------------------------------------------
module tb_regfile_dump_reader;
   import mips_pkg::*;

   localparam int NREG = NUM_GPR;

   typedef struct {
      int          idx;
      logic [31:0] data;
   } word_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [4:0]  readRegister;
   logic [31:0] readData;
   logic [31:0] dumpData;
   logic [4:0]  dumpIndex;
   logic        dumpValid;
   logic        dumpReady = 1'b0;
   logic        busy;
   logic        freeze;
   logic        done;

   int          testsRun = 0;
   int          testsFailed = 0;

   logic [31:0] regs [NREG];
   bit          wrEn = 1'b0;
   bit          monEn = 1'b0;

   // reference model state
   word_t       sbQ [$];
   bit          mActive = 1'b0;
   bit          mLoading = 1'b0;
   int          mRemaining = 0;
   bit          expDone = 1'b0;
   logic        expValid;

   assign expValid = mActive && !mLoading;

   // Register 0 is hardwired to zero in the register file being modelled
   assign readData = (readRegister == 5'd0) ? 32'd0 : regs[readRegister];

   always #5 clk = ~clk;

   regfile_dump_reader dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .readRegister (readRegister),
      .readData     (readData),
      .dumpData     (dumpData),
      .dumpIndex    (dumpIndex),
      .dumpValid    (dumpValid),
      .dumpReady    (dumpReady),
      .busy         (busy),
      .freeze       (freeze),
      .done         (done)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                  name, actual, expected, $time);
      end
   endtask

   // Reference model: a started dump owes NREG words, a snapshot of the
   // register file at the moment of start (freeze keeps it unchanged).
   // One idle cycle of loading passes before the first word is on offer;
   // every edge with a word on offer and ready high retires one word.
   always @(posedge clk) begin
      if (rst) begin
         mActive  = 1'b0;
         mLoading = 1'b0;
         expDone  = 1'b0;
         sbQ.delete();
      end else begin
         expDone = 1'b0;
         if (mActive) begin
            if (mLoading) begin
               mLoading = 1'b0;
            end else if (dumpReady) begin
               mRemaining--;
               if (mRemaining == 0) begin
                  mActive = 1'b0;
                  expDone = 1'b1;
               end
            end
         end else if (start) begin
            mActive    = 1'b1;
            mLoading   = 1'b1;
            mRemaining = NREG;
            for (int i = 0; i < NREG; i++) begin
               word_t w;
               w.idx  = i;
               w.data = (i == 0) ? 32'd0 : regs[i];
               sbQ.push_back(w);
            end
         end
      end
   end

   // Monitor: compares flags every cycle and the offered word against the
   // head of the scoreboard; the head is retired only when accepted
   always @(negedge clk) begin
      if (monEn) begin
         checkOutput("dumpValid", {31'd0, dumpValid}, {31'd0, expValid});
         checkOutput("busy", {31'd0, busy}, {31'd0, mActive});
         checkOutput("freeze", {31'd0, freeze}, {31'd0, mActive});
         checkOutput("done", {31'd0, done}, {31'd0, expDone});
         if (expDone) begin
            checkOutput("wordsLeftAtDone", sbQ.size(), 32'd0);
         end
         if (dumpValid && expValid) begin
            if (sbQ.size() == 0) begin
               checkOutput("scoreboardEmpty", 32'd1, 32'd0);
            end else begin
               checkOutput("dumpIndex", {27'd0, dumpIndex}, sbQ[0].idx);
               checkOutput("dumpData", dumpData, sbQ[0].data);
               if (dumpReady) begin
                  void'(sbQ.pop_front());
               end
            end
         end
      end
   end

   // Drive one cycle of inputs; optionally scribble on a register while the
   // core is allowed to write (freeze low)
   task automatic applyStimulus(input bit s, input bit r, input bit rs);
      start     = s;
      dumpReady = r;
      rst       = rs;
      if (wrEn && !freeze) begin
         regs[$urandom_range(NREG - 1)] = $urandom;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic waitIndex(input int target, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 300; n++) begin
         if (dumpValid && dumpIndex == 5'(target)) begin
            ok = 1'b1;
            break;
         end
         applyStimulus(1'b0, 1'b1, 1'b0);
      end
      if (!ok) checkOutput("waitIndexTimeout", 32'd0, 32'd1);
   endtask

   task automatic runUntilDone(input bit toggle, output int cycles);
      bit r;
      r = 1'b1;
      cycles = 0;
      for (int n = 0; n < 400; n++) begin
         if (toggle) r = ~r;
         applyStimulus(1'b0, r, 1'b0);
         cycles++;
         if (done) break;
      end
      if (!done) checkOutput("doneTimeout", 32'd0, 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      int  cyc;
      int  doneCount;
      int  lowRun;
      bit  seenHigh;
      bit  ok;

      for (int i = 0; i < NREG; i++) regs[i] = 32'h1000_0000 + i;

      // reset state
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("resetValid", {31'd0, dumpValid}, 32'd0);
      checkOutput("resetBusy", {31'd0, busy}, 32'd0);
      checkOutput("resetDone", {31'd0, done}, 32'd0);
      checkOutput("resetIndex", {27'd0, dumpIndex}, 32'd0);
      checkOutput("resetData", dumpData, 32'd0);
      checkOutput("resetReadReg", {27'd0, readRegister}, 32'd0);
      monEn = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0);

      // full dump with ready high: done 33 cycles after start
      $display("[TB] straight dump");
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("loadCycleValid", {31'd0, dumpValid}, 32'd0);
      runUntilDone(1'b0, cyc);
      checkOutput("startToDone", cyc, 32'd33);

      // toggled ready
      $display("[TB] toggled ready");
      applyStimulus(1'b1, 1'b1, 1'b0);
      runUntilDone(1'b1, cyc);

      // stall 10 cycles at index 5
      $display("[TB] stall at index 5");
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitIndex(5, ok);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         checkOutput("stallIndex", {27'd0, dumpIndex}, 32'd5);
         checkOutput("stallData", dumpData, 32'h1000_0005);
         checkOutput("stallBusy", {31'd0, busy}, 32'd1);
      end
      runUntilDone(1'b0, cyc);

      // start mid-dump ignored
      $display("[TB] start at index 12");
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitIndex(12, ok);
      applyStimulus(1'b1, 1'b1, 1'b0);
      doneCount = 0;
      for (int k = 0; k < 60; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0);
         if (done) doneCount++;
      end
      checkOutput("midStartDonePulses", doneCount, 32'd1);

      // reset at index 20 aborts, later dump restarts at 0
      $display("[TB] reset at index 20");
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitIndex(20, ok);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("abortValid", {31'd0, dumpValid}, 32'd0);
      checkOutput("abortBusy", {31'd0, busy}, 32'd0);
      checkOutput("abortDone", {31'd0, done}, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("restartIndex", {27'd0, dumpIndex}, 32'd0);
      runUntilDone(1'b0, cyc);

      // start held high: back-to-back dumps with one idle cycle between
      $display("[TB] continuous start");
      lowRun   = 0;
      seenHigh = 1'b0;
      for (int k = 0; k < 3 * 34 + 5; k++) begin
         applyStimulus(1'b1, 1'b1, 1'b0);
         if (freeze) begin
            if (seenHigh && lowRun > 0) checkOutput("freezeGap", lowRun, 32'd1);
            lowRun   = 0;
            seenHigh = 1'b1;
         end else if (seenHigh) begin
            lowRun++;
         end
      end
      for (int k = 0; k < 40; k++) applyStimulus(1'b0, 1'b1, 1'b0);

      // randomized traffic with register writes while not frozen
      $display("[TB] random traffic");
      wrEn = 1'b1;
      for (int k = 0; k < 4000; k++) begin
         applyStimulus($urandom_range(7) == 0, $urandom_range(3) != 0,
                       $urandom_range(600) == 0);
      end
      wrEn = 1'b0;
      for (int k = 0; k < 80; k++) applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("drainedWords", sbQ.size(), 32'd0);
      checkOutput("finalBusy", {31'd0, busy}, 32'd0);

      monEn = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
